// File: rtl/fifo_pkg.sv
// Shared constants, pointer-sizing helper and status bundle for the sync_fifo_param library block.
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 16;

  // Ceiling log2; used at elaboration time to size addresses and pointers.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: stored words are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy, thresholds and error pulses.
// Define FIFO_FWFT_EN for first-word fall-through; default is a 1-cycle registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    rd,
  output logic [DATA_W-1:0]       data_out,
  output logic                    data_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, underflow_q;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] rd_data;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign rd_acc   = rd & ~empty;
  assign wr_acc   = wr & (~full | rd_acc);
  assign wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= wr & ~wr_acc;
      underflow_q <= rd & ~rd_acc;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

`ifdef FIFO_FWFT_EN
  // Head word is shown straight from the array; zero while nothing is stored.
  assign data_out   = empty ? '0 : rd_data;
  assign data_valid = ~empty;
`else
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_acc;
      if (rd_acc) begin
        data_out_q <= rd_data;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2).
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          data_valid, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [4:0]    count;

  int errors = 0;
  int checks = 0;
  int txn = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] last_data = '0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .data_in      (data_in),
    .rd           (rd),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // One clock of stimulus; the scoreboard predicts the result and compares it after the edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    logic         rd_acc, wr_acc, exp_dv;
    logic [DW-1:0] popped, exp_do;
    fifo_status_t exp_st, got_st;
    int           n;
    popped = last_data;
    rd_acc = r && (model_q.size() != 0);
    wr_acc = w && ((model_q.size() < DEPTH) || rd_acc);
    if (rd_acc) popped = model_q.pop_front();
    if (wr_acc) model_q.push_back(d);
    wr = w; data_in = d; rd = r;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    n = model_q.size();
`ifdef FIFO_FWFT_EN
    exp_dv = (n != 0);
    exp_do = (n != 0) ? model_q[0] : '0;
`else
    exp_dv = rd_acc;
    exp_do = popped;
    last_data = popped;
`endif
    exp_st.full         = (n == DEPTH);
    exp_st.empty        = (n == 0);
    exp_st.almost_full  = (n >= AF);
    exp_st.almost_empty = (n <= AE);
    exp_st.overflow     = w && !wr_acc;
    exp_st.underflow    = r && !rd_acc;
    got_st = '{full, empty, almost_full, almost_empty, overflow, underflow};
    txn++;
    $display("txn %0d wr=%b din=%h rd=%b -> dout=%h dv=%b cnt=%0d st=%b",
             txn, w, d, r, data_out, data_valid, count, got_st);
    checks++;
    if (count !== 5'(n)) begin
      errors++; $display("FAIL count: got %0d expected %0d", count, n);
    end
    checks++;
    if (got_st !== exp_st) begin
      errors++; $display("FAIL status: got %b expected %b", got_st, exp_st);
    end
    checks++;
    if (data_valid !== exp_dv) begin
      errors++; $display("FAIL data_valid: got %b expected %b", data_valid, exp_dv);
    end
    checks++;
    if (data_out !== exp_do) begin
      errors++; $display("FAIL data_out: got %h expected %h", data_out, exp_do);
    end
  endtask

  // Reset asserted together with a write; nothing may be stored.
  task automatic test_reset();
    rst = 1'b1; wr = 1'b1; data_in = 8'h99; rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; wr = 1'b0;
    model_q.delete();
    last_data = '0;
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
      errors++; $display("FAIL reset_flags: got %b expected 0101", {full, empty, almost_full, almost_empty});
    end
    checks++;
    if ({data_valid, overflow, underflow} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {data_valid, overflow, underflow});
    end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", data_out); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL ovf_pulse: got ovf=%b cnt=%0d expected ovf=1 cnt=16", overflow, count);
    end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_rw: got cnt=%0d ovf=%b expected cnt=16 ovf=0", count, overflow);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
    checks++;
    if (data_out !== 8'h55) begin errors++; $display("FAIL full_rw_last: got %h expected 55", data_out); end
`endif
  endtask

  task automatic test_underflow();
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (underflow !== 1'b1 || data_valid !== 1'b0) begin
      errors++; $display("FAIL udf_empty: got udf=%b dv=%b expected udf=1 dv=0", underflow, data_valid);
    end
    cycle(1'b1, 8'h77, 1'b1);
    checks++;
    if (underflow !== 1'b1 || count !== 5'd1) begin
      errors++; $display("FAIL udf_rw: got udf=%b cnt=%0d expected udf=1 cnt=1", underflow, count);
    end
    cycle(1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
    checks++;
    if (data_out !== 8'h77) begin errors++; $display("FAIL udf_readback: got %h expected 77", data_out); end
`endif
  endtask

  task automatic test_thresholds_random();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b0);
      if (i == AF - 1 || i == AF) begin
        checks++;
        if (almost_full !== (i == AF)) begin
          errors++; $display("FAIL af_edge: cnt=%0d got %b expected %b", i, almost_full, (i == AF));
        end
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (i == AE || i == AE + 1) begin
        checks++;
        if (almost_empty !== (i == AE)) begin
          errors++; $display("FAIL ae_edge: cnt=%0d got %b expected %b", i, almost_empty, (i == AE));
        end
      end
    end
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45));
    end
    while (model_q.size() != 0) cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    test_reset();
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL rst_discard: got udf=%b expected 1", underflow); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_thresholds_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
